sm_rr_merge: RTL
================

Name: sm_rr_merge

Overview:
- Merges N independent valid-only producer streams into the single valid-only input of the sm_dut datapath (i_dval / i).
- The datapath has no backpressure, so each producer is buffered in its own small FIFO.
- A round-robin scheduler issues at most one word per cycle to the datapath.
- Sits directly in front of sm_dut and drives its i_dval and i ports.

Parameters:
- N, 4, number of producer streams (2..8).
- DW, 8, data word width in bits.
- DEPTH, 4, entries per producer FIFO (power of 2, >= 2).
- SW, $clog2(N), width of the source index (derived; not overridable).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (0 = in reset).
- s_dval  input  N  per-producer valid; bit k qualifies word k of s_data.
- s_data  input  N*DW  packed producer words; word k occupies bits [k*DW +: DW].
- o_dval  output  1  valid to datapath (connects to sm_dut i_dval).
- o  output  DW  data to datapath (connects to sm_dut i).
- o_src  output  SW  index of the producer whose word is on o; valid only when o_dval=1.
- busy  output  1  1 when any FIFO is non-empty or o_dval=1.
- ovf  output  N  sticky per-producer overflow flags (only when SM_MERGE_OVF_EN is defined).
- ovf_clr  input  1  synchronous clear of all ovf bits (only when SM_MERGE_OVF_EN is defined).

Behaviour:
Reset (rst=0, asynchronous):
- All FIFOs empty; read and write pointers 0.
- o_dval=0, o=0, o_src=0, busy=0, ovf=0.
- Round-robin pointer last=N-1, so producer 0 has first priority.

Push:
- On each posedge with s_dval[k]=1, word k is written into FIFO k.
- If FIFO k is full and is not popped in the same cycle, the word is dropped and the FIFO is unchanged.
- If FIFO k is full and is popped in the same cycle, the push is accepted (simultaneous push and pop on a full FIFO never drops).

Arbitration (combinational on registered FIFO state):
- Candidates are the FIFOs that are non-empty at the start of the cycle.
- Search order is last+1, last+2, ... modulo N; the first non-empty FIFO wins as g.
- No candidate means no grant.

Issue:
- On a grant, FIFO g pops its head at the posedge.
- After that edge: o_dval=1, o=head of g, o_src=g, last=g.
- Without a grant: o_dval=0 next cycle, and o and o_src hold their previous values.
- o_dval is asserted for exactly one cycle per word; there is no backpressure.

Latency and ordering:
- A word sampled at edge E0 into an empty, uncontended FIFO appears on o after edge E1 (1 cycle).
- A word pushed into an empty FIFO is not visible to the arbiter until the next cycle; there is no bypass.
- Order within a stream is preserved.
- Throughput is 1 word/cycle total.
- Under full contention each producer is served once every N cycles.

Other rules:
- busy is combinational: OR of the FIFO non-empty flags and o_dval.
- Pointers are log2(DEPTH)+1 bits wide; wrap is natural.
- Full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
- Reset asserted mid-operation discards all buffered words immediately.
- The first grant after release goes to the lowest-index non-empty FIFO.

Optional Feature:
SM_MERGE_OVF_EN
- Defined:
  - ovf and ovf_clr ports exist.
  - ovf[k] is set on the edge where a word from producer k is dropped.
  - ovf[k] stays set until ovf_clr=1 is sampled.
  - If a drop and ovf_clr occur in the same cycle, the set wins.
- Not defined:
  - Ports and flag registers are absent.
  - Drops are silent; all other behaviour is identical.

Test Plan:
1. Reset: hold rst=0 for 5 cycles with s_dval toggling -> o_dval=0, busy=0, ovf=0 throughout; after release, the first grant goes to producer 0 if it is non-empty.
2. Single stream: s_dval=4'b0010 for one cycle with word 0x5A -> o_dval=1 with o=0x5A and o_src=1 exactly one cycle later; busy drops the following cycle.
3. Full contention: N=4, all producers push 1 word in the same cycle (0x10, 0x11, 0x12, 0x13) -> o_src sequence 0,1,2,3 on 4 consecutive cycles, and o matches each word.
4. Fairness: producers 0 and 2 push every cycle for 20 cycles -> o_src strictly alternates 0,2,0,2; FIFO 0 and FIFO 2 drain in order.
5. Overflow (SM_MERGE_OVF_EN): producers 0..3 all push every cycle for 12 cycles with DEPTH=4 ->
   - ovf bits set for the producers that drop.
   - Surviving words emerge in per-stream order.
   - ovf_clr clears the flags.
   - Build without the macro: same o stream, and the ports are absent.
6. Reset mid-burst: assert rst=0 while 3 FIFOs hold data -> o_dval=0 immediately; after release no stale word ever appears on o.

Source files
------------

// File: rtl/sm_rr_merge.sv
// sm_rr_merge: per-producer FIFOs feeding one valid-only datapath input via a round-robin scheduler.
// Optional macro SM_MERGE_OVF_EN adds sticky per-producer overflow flags (ovf) and their clear (ovf_clr).
module sm_rr_merge #(
  parameter  int N     = 4,
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  localparam int SW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    s_dval,
  input  logic [N*DW-1:0] s_data,
`ifdef SM_MERGE_OVF_EN
  input  logic            ovf_clr,
  output logic [N-1:0]    ovf,
`endif
  output logic            o_dval,
  output logic [DW-1:0]   o,
  output logic [SW-1:0]   o_src,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [N][DEPTH];
  logic [AW:0]   r_wp [N];
  logic [AW:0]   r_rp [N];
  logic          r_o_dval;
  logic [DW-1:0] r_o;
  logic [SW-1:0] r_o_src;
  logic [SW-1:0] r_last;

  logic [N-1:0]  w_empty;
  logic [N-1:0]  w_full;
  logic [N-1:0]  w_pop;
  logic [N-1:0]  w_push;
  logic          w_gnt_vld;
  logic [SW-1:0] w_gnt;
  logic [SW:0]   w_cand;
  logic [DW-1:0] w_head;

  // FIFO status from registered pointers; a word written this cycle is invisible until the next
  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int k = 0; k < N; k++) begin
      w_empty[k] = (r_wp[k] == r_rp[k]);
      w_full[k]  = (r_wp[k][AW] != r_rp[k][AW]) &&
                   (r_wp[k][AW-1:0] == r_rp[k][AW-1:0]);
    end
  end

  // Round-robin search starting one past the last producer served
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_cand    = '0;
    for (int i = 1; i <= N; i++) begin
      w_cand = {1'b0, r_last} + (SW+1)'(i);
      if (w_cand >= (SW+1)'(N)) begin
        w_cand = w_cand - (SW+1)'(N);
      end else begin
      end
      if (!w_gnt_vld && !w_empty[w_cand[SW-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_cand[SW-1:0];
      end else begin
      end
    end
  end

  // Pop the granted FIFO; a full FIFO being popped still accepts its push
  always_comb begin
    w_pop  = '0;
    w_push = '0;
    for (int k = 0; k < N; k++) begin
      w_pop[k]  = w_gnt_vld && (w_gnt == SW'(k));
      w_push[k] = s_dval[k] && (!w_full[k] || w_pop[k]);
    end
  end

  assign w_head = r_mem[w_gnt][r_rp[w_gnt][AW-1:0]];

  // FIFO storage; contents are qualified by the pointers so no reset is needed
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (w_push[k]) begin
        r_mem[k][r_wp[k][AW-1:0]] <= s_data[k*DW +: DW];
      end
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        r_wp[k] <= '0;
        r_rp[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w_push[k]) begin
          r_wp[k] <= r_wp[k] + (AW+1)'(1);
        end
        if (w_pop[k]) begin
          r_rp[k] <= r_rp[k] + (AW+1)'(1);
        end
      end
    end
  end

  // Issue register: o and o_src hold their value on idle cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_o_dval <= 1'b0;
      r_o      <= '0;
      r_o_src  <= '0;
      r_last   <= SW'(N - 1);
    end else if (w_gnt_vld) begin
      r_o_dval <= 1'b1;
      r_o      <= w_head;
      r_o_src  <= w_gnt;
      r_last   <= w_gnt;
    end else begin
      r_o_dval <= 1'b0;
    end
  end

`ifdef SM_MERGE_OVF_EN
  logic [N-1:0] w_drop;
  logic [N-1:0] r_ovf;

  assign w_drop = s_dval & w_full & ~w_pop;

  // Sticky drop flags; a drop in the clearing cycle wins over the clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (ovf_clr ? '0 : r_ovf) | w_drop;
    end
  end

  assign ovf = r_ovf;
`endif

  assign o_dval = r_o_dval;
  assign o      = r_o;
  assign o_src  = r_o_src;
  assign busy   = (|(~w_empty)) | r_o_dval;

endmodule
